// File: rtl/display_scheduler.sv
// Time-shares a four-digit seven-segment display among four sources and an alert channel.
// Round-robin rotation on a tick-based dwell timer; alerts pre-empt rotation for a fixed time.
module display_scheduler #(
    parameter logic [15:0] TICK_DIV    = 16'd50000,
    parameter logic [7:0]  DWELL_TICKS = 8'd100,
    parameter logic [7:0]  ALERT_TICKS = 8'd200,
    parameter logic [15:0] SCAN_DIV    = 16'd12500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_valid,
    input  logic [63:0] src_data,
    input  logic        alert_req,
    input  logic [15:0] alert_data,
    output logic        alert_ack,
    input  logic        hold,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic        blank,
    output logic [1:0]  cur_src,
    output logic        alert_active,
    output logic        scan_en
);

    typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

    state_t      state, state_nxt;
    logic [15:0] presc, scan_cnt;
    logic        tick, scan_wrap;
    logic [7:0]  dwell, dwell_nxt;
    logic [7:0]  acnt, acnt_nxt;
    logic [1:0]  cur_nxt;
    logic        accept;
    logic        dwell_done, alert_done;
    logic [15:0] alert_reg;
    logic [15:0] disp;

    // First valid source strictly after cur, wrapping; returns cur itself when it is the only one.
    function automatic logic [1:0] next_valid(input logic [1:0] cur, input logic [3:0] valid);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = cur + k[1:0];
            if (!found && valid[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign tick       = (TICK_DIV <= 16'd1) || (presc == TICK_DIV - 16'd1);
    assign scan_wrap  = (SCAN_DIV <= 16'd1) || (scan_cnt == SCAN_DIV - 16'd1);
    assign dwell_done = (DWELL_TICKS <= 8'd1) || (dwell == DWELL_TICKS - 8'd1);
    assign alert_done = (ALERT_TICKS <= 8'd1) || (acnt == ALERT_TICKS - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            scan_cnt <= '0;
            scan_en  <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + 16'd1;
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 16'd1;
            scan_en  <= scan_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Alert acceptance outranks source loss and rotation; entry cycle ignores any coincident tick.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_src;
        dwell_nxt = dwell;
        acnt_nxt  = acnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (alert_req) begin
                    accept = 1'b1;
                end else if (|src_valid) begin
                    state_nxt = SHOW;
                    cur_nxt   = next_valid(2'd3, src_valid);
                    dwell_nxt = '0;
                end
            end
            SHOW: begin
                if (alert_req) begin
                    accept = 1'b1;
                end else if (src_valid == 4'b0000) begin
                    state_nxt = IDLE;
                end else if (!src_valid[cur_src]) begin
                    cur_nxt   = next_valid(cur_src, src_valid);
                    dwell_nxt = '0;
                end else if (tick && !hold) begin
                    if (dwell_done) begin
                        cur_nxt   = next_valid(cur_src, src_valid);
                        dwell_nxt = '0;
                    end else begin
                        dwell_nxt = dwell + 8'd1;
                    end
                end
            end
            ALERT: begin
                if (tick) begin
                    if (alert_done) begin
                        dwell_nxt = '0;
                        if (src_valid[cur_src]) begin
                            state_nxt = SHOW;
                        end else if (|src_valid) begin
                            state_nxt = SHOW;
                            cur_nxt   = next_valid(cur_src, src_valid);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        acnt_nxt = acnt + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            state_nxt = ALERT;
            acnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_src   <= '0;
            dwell     <= '0;
            acnt      <= '0;
            alert_reg <= '0;
            alert_ack <= 1'b0;
            disp      <= '0;
        end else begin
            cur_src   <= cur_nxt;
            dwell     <= dwell_nxt;
            acnt      <= acnt_nxt;
            alert_ack <= accept;
            if (accept) begin
                alert_reg <= alert_data;
                disp      <= alert_data;
            end else begin
                case (state)
                    SHOW:    disp <= src_data[{cur_src, 4'b0000} +: 16];
                    ALERT:   disp <= alert_reg;
                    default: disp <= '0;
                endcase
            end
        end
    end

    always_comb begin
        blank        = 1'b1;
        alert_active = 1'b0;
        case (state)
            SHOW:    blank = 1'b0;
            ALERT: begin
                blank        = 1'b0;
                alert_active = 1'b1;
            end
            default: blank = 1'b1;
        endcase
    end

    assign digit0 = disp[3:0];
    assign digit1 = disp[7:4];
    assign digit2 = disp[11:8];
    assign digit3 = disp[15:12];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with short tick/scan periods.
// Tick edges are tracked by a bench-side edge counter that restarts with rst.
module tb_display_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_valid;
    logic [63:0] src_data;
    logic        alert_req;
    logic [15:0] alert_data;
    logic        alert_ack;
    logic        hold;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic        blank;
    logic [1:0]  cur_src;
    logic        alert_active;
    logic        scan_en;
    logic [15:0] disp;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [15:0] dat [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    display_scheduler #(
        .TICK_DIV   (16'd4),
        .DWELL_TICKS(8'd3),
        .ALERT_TICKS(8'd2),
        .SCAN_DIV   (16'd5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .alert_req   (alert_req),
        .alert_data  (alert_data),
        .alert_ack   (alert_ack),
        .hold        (hold),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .blank       (blank),
        .cur_src     (cur_src),
        .alert_active(alert_active),
        .scan_en     (scan_en)
    );

    assign disp = {digit3, digit2, digit1, digit0};

    always #5 clk = ~clk;

    // Edges since the last reset edge: prescaler ticks land on edges with edge_n % 4 == 0.
    always @(posedge clk) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_src_change(input int start, output int cnt);
        logic [1:0] prev;
        prev = cur_src;
        cnt  = start;
        do begin
            tick_wait(1);
            cnt++;
        end while (cur_src == prev && cnt < start + 40);
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        alert_req  = 1'b1;
        alert_data = 16'hDEAD;
        src_valid  = 4'hF;
        src_data   = {dat[3], dat[2], dat[1], dat[0]};
        hold       = 1'b0;
        tick_wait(3);
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank: got %b want 1", blank); end
        n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", disp); end
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL reset_cur_src: got %0d want 0", cur_src); end
        n_checks++; if (alert_active !== 1'b0) begin n_fail++; $display("FAIL reset_alert_active: got %b want 0", alert_active); end
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL reset_alert_ack: got %b want 0", alert_ack); end
        n_checks++; if (scan_en !== 1'b0) begin n_fail++; $display("FAIL reset_scan_en: got %b want 0", scan_en); end
        rst       = 1'b0;
        alert_req = 1'b0;
        src_valid = 4'h0;
    endtask

    task automatic test_idle;
        logic exp_scan;
        repeat (1000) begin
            tick_wait(1);
            exp_scan = (edge_n % 5 == 0);
            n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL idle_blank: got %b want 1 at edge %0d", blank, edge_n); end
            n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL idle_digits: got %h want 0000 at edge %0d", disp, edge_n); end
            n_checks++; if (alert_active !== 1'b0) begin n_fail++; $display("FAIL idle_alert_active: got %b want 0 at edge %0d", alert_active, edge_n); end
            n_checks++; if (scan_en !== exp_scan) begin n_fail++; $display("FAIL idle_scan_en: got %b want %b at edge %0d", scan_en, exp_scan, edge_n); end
        end
    endtask

    task automatic test_rotation;
        logic [1:0] seq [4] = '{2'd1, 2'd3, 2'd0, 2'd1};
        int cnt;
        src_valid = 4'b1011;
        tick_wait(1);
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL rot_entry_src: got %0d want 0", cur_src); end
        n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL rot_entry_blank: got %b want 0", blank); end
        tick_wait(1);
        n_checks++; if (disp !== dat[0]) begin n_fail++; $display("FAIL rot_entry_digits: got %h want %h", disp, dat[0]); end
        for (int i = 0; i < 4; i++) begin
            wait_src_change((i == 0) ? 0 : 1, cnt);
            n_checks++; if (cur_src !== seq[i]) begin n_fail++; $display("FAIL rot_src[%0d]: got %0d want %0d", i, cur_src, seq[i]); end
            if (i > 0) begin
                n_checks++; if (cnt !== 12) begin n_fail++; $display("FAIL rot_interval[%0d]: got %0d clks want 12", i, cnt); end
            end
            tick_wait(1);
            n_checks++; if (disp !== dat[seq[i]]) begin n_fail++; $display("FAIL rot_digits[%0d]: got %h want %h", i, disp, dat[seq[i]]); end
        end
    endtask

    task automatic test_source_loss;
        int cnt;
        tick_wait(7);
        src_valid = 4'b1001;
        tick_wait(1);
        n_checks++; if (cur_src !== 2'd3) begin n_fail++; $display("FAIL loss_src: got %0d want 3", cur_src); end
        wait_src_change(0, cnt);
        n_checks++; if (cnt !== 11) begin n_fail++; $display("FAIL loss_dwell_restart: got %0d clks want 11", cnt); end
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL loss_next_src: got %0d want 0", cur_src); end
        src_valid = 4'b0000;
        tick_wait(1);
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL loss_idle_blank: got %b want 1", blank); end
        tick_wait(1);
        n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL loss_idle_digits: got %h want 0000", disp); end
    endtask

    task automatic test_alert;
        int cnt;
        src_valid = 4'b0011;
        tick_wait(1);
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL alert_pre_src: got %0d want 0", cur_src); end
        while (edge_n % 4 != 3) tick_wait(1);
        alert_data = 16'hBEEF;
        alert_req  = 1'b1;
        tick_wait(1);
        alert_req  = 1'b0;
        n_checks++; if (alert_ack !== 1'b1) begin n_fail++; $display("FAIL alert_ack_pulse: got %b want 1", alert_ack); end
        n_checks++; if (alert_active !== 1'b1) begin n_fail++; $display("FAIL alert_active_on: got %b want 1", alert_active); end
        n_checks++; if (disp !== 16'hBEEF) begin n_fail++; $display("FAIL alert_digits: got %h want beef", disp); end
        n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL alert_blank: got %b want 0", blank); end
        tick_wait(1);
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL alert_ack_width: got %b want 0", alert_ack); end
        tick_wait(2);
        alert_data = 16'h1234;
        alert_req  = 1'b1;
        tick_wait(1);
        alert_req  = 1'b0;
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL alert_no_reack: got %b want 0", alert_ack); end
        n_checks++; if (disp !== 16'hBEEF) begin n_fail++; $display("FAIL alert_digits_held: got %h want beef", disp); end
        tick_wait(3);
        n_checks++; if (alert_active !== 1'b1) begin n_fail++; $display("FAIL alert_active_7: got %b want 1", alert_active); end
        tick_wait(1);
        n_checks++; if (alert_active !== 1'b0) begin n_fail++; $display("FAIL alert_exit_8: got %b want 0", alert_active); end
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL alert_return_src: got %0d want 0", cur_src); end
        n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL alert_return_blank: got %b want 0", blank); end
        tick_wait(1);
        n_checks++; if (disp !== dat[0]) begin n_fail++; $display("FAIL alert_return_digits: got %h want %h", disp, dat[0]); end
        wait_src_change(1, cnt);
        n_checks++; if (cnt !== 12) begin n_fail++; $display("FAIL alert_fresh_dwell: got %0d clks want 12", cnt); end
        n_checks++; if (cur_src !== 2'd1) begin n_fail++; $display("FAIL alert_next_src: got %0d want 1", cur_src); end
    endtask

    task automatic test_hold;
        int cnt;
        hold = 1'b1;
        for (int p = 0; p < 10; p++) begin
            tick_wait(12);
            n_checks++; if (cur_src !== 2'd1) begin n_fail++; $display("FAIL hold_src[%0d]: got %0d want 1", p, cur_src); end
        end
        while (edge_n % 4 != 3) tick_wait(1);
        alert_data = 16'hCAFE;
        alert_req  = 1'b1;
        tick_wait(1);
        alert_req  = 1'b0;
        n_checks++; if (alert_ack !== 1'b1) begin n_fail++; $display("FAIL hold_alert_ack: got %b want 1", alert_ack); end
        n_checks++; if (disp !== 16'hCAFE) begin n_fail++; $display("FAIL hold_alert_digits: got %h want cafe", disp); end
        cnt = 0;
        do begin
            tick_wait(1);
            cnt++;
        end while (alert_active && cnt < 20);
        n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL hold_alert_len: got %0d clks want 8", cnt); end
        n_checks++; if (cur_src !== 2'd1) begin n_fail++; $display("FAIL hold_alert_return: got %0d want 1", cur_src); end
        hold = 1'b0;
        wait_src_change(0, cnt);
        n_checks++; if (cnt !== 12) begin n_fail++; $display("FAIL hold_resume_dwell: got %0d clks want 12", cnt); end
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL hold_resume_src: got %0d want 0", cur_src); end
    endtask

    task automatic test_reset_mid;
        alert_data = 16'h1357;
        alert_req  = 1'b1;
        tick_wait(1);
        alert_req  = 1'b0;
        n_checks++; if (alert_ack !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_ack: got %b want 1", alert_ack); end
        tick_wait(2);
        n_checks++; if (alert_active !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_active: got %b want 1", alert_active); end
        rst       = 1'b1;
        alert_req = 1'b1;
        tick_wait(1);
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL rmid_blank: got %b want 1", blank); end
        n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL rmid_digits: got %h want 0000", disp); end
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL rmid_cur_src: got %0d want 0", cur_src); end
        n_checks++; if (alert_active !== 1'b0) begin n_fail++; $display("FAIL rmid_alert_active: got %b want 0", alert_active); end
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_alert_ack: got %b want 0", alert_ack); end
        n_checks++; if (scan_en !== 1'b0) begin n_fail++; $display("FAIL rmid_scan_en: got %b want 0", scan_en); end
        tick_wait(1);
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_req_in_reset_ack: got %b want 0", alert_ack); end
        rst       = 1'b0;
        alert_req = 1'b0;
        src_valid = 4'b0000;
        tick_wait(3);
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL rmid_idle_blank: got %b want 1", blank); end
        n_checks++; if (alert_active !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_active: got %b want 0", alert_active); end
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_ack: got %b want 0", alert_ack); end
        n_checks++; if (disp !== 16'h0000) begin n_fail++; $display("FAIL rmid_idle_digits: got %h want 0000", disp); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle();
        test_rotation();
        test_source_loss();
        test_alert();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
